// File: rtl/parking_occupancy_ctrl.sv
// Parking lot occupancy controller: sensor sync/debounce, saturating car count with timed error
// flag, and sequential double-dabble conversion of occupied/free counts for the 7-seg driver.
module parking_occupancy_ctrl #(
  parameter int unsigned CAPACITY   = 99,
  parameter int unsigned DEB_CYCLES = 2500,
  parameter int unsigned ERR_HOLD   = 50_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        car_in_i,
  input  logic        car_out_i,
  input  logic        show_text_i,
  output logic [3:0]  d0_o,
  output logic [3:0]  d1_o,
  output logic [3:0]  d2_o,
  output logic [3:0]  d3_o,
  output logic [3:0]  d4_o,
  output logic [3:0]  d5_o,
  output logic [3:0]  d6_o,
  output logic [3:0]  d7_o,
  output logic        text_mode_o,
  output logic        slow_o,
  output logic        med_o,
  output logic        fast_o,
  output logic        error_o,
  output logic [13:0] occupied_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int unsigned TmrW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD + 1) : 1;
  localparam logic [13:0] Cap14 = 14'(CAPACITY);
  localparam logic [31:0] Cap32 = 32'(CAPACITY);
  localparam logic [31:0] Cap3x = 32'(3 * CAPACITY);

  // Index 0 = entry sensor, index 1 = exit sensor.
  logic [1:0]      s1_q, s2_q, deb_q, ev_q;
  logic [DebW-1:0] cnt_q [2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      deb_q <= '0;
      ev_q  <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= {car_out_i, car_in_i};
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        ev_q[i] <= 1'b0;
        if (s2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          cnt_q[i] <= '0;
          deb_q[i] <= s2_q[i];
          ev_q[i]  <= s2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic [13:0]     occ_q, occ_d;
  logic            full_q, empty_q, slow_q, med_q, fast_q, err_q, chg_q;
  logic            err_ev;
  logic [TmrW-1:0] tmr_q;
  logic [31:0]     occ_x4;

  always_comb begin
    occ_d  = occ_q;
    err_ev = 1'b0;
    if (ev_q[0] && !ev_q[1]) begin
      if (full_q) err_ev = 1'b1;
      else        occ_d  = occ_q + 14'd1;
    end else if (ev_q[1] && !ev_q[0]) begin
      if (empty_q) err_ev = 1'b1;
      else         occ_d  = occ_q - 14'd1;
    end
    occ_x4 = {16'd0, occ_d, 2'b00};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      slow_q  <= 1'b1;
      med_q   <= 1'b0;
      fast_q  <= 1'b0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      occ_q   <= occ_d;
      full_q  <= (occ_d == Cap14);
      empty_q <= (occ_d == 14'd0);
      slow_q  <= (occ_x4 < Cap32);
      fast_q  <= (occ_x4 >= Cap3x);
      med_q   <= !(occ_x4 < Cap32) && !(occ_x4 >= Cap3x);
      chg_q   <= (occ_d != occ_q);
      if (err_ev) begin
        err_q <= 1'b1;
        tmr_q <= TmrW'(ERR_HOLD);
      end else if (err_q) begin
        if (tmr_q <= TmrW'(1)) begin
          err_q <= 1'b0;
          tmr_q <= '0;
        end else begin
          tmr_q <= tmr_q - 1'b1;
        end
      end
    end
  end

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit.
  function automatic logic [15:0] dd_shift(input logic [15:0] b, input logic nb);
    logic [15:0] t;
    t = b;
    for (int i = 0; i < 4; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[14:0], nb};
  endfunction

  logic        busy_q, pend_q, init_q, start;
  logic [3:0]  step_q;
  logic [13:0] bin_occ_q, bin_free_q;
  logic [15:0] bcd_occ_q, bcd_free_q, dig_occ_q, dig_free_q;
  logic [15:0] nxt_occ, nxt_free;

  assign start    = !busy_q && (init_q || chg_q || pend_q);
  assign nxt_occ  = dd_shift(bcd_occ_q, bin_occ_q[13]);
  assign nxt_free = dd_shift(bcd_free_q, bin_free_q[13]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      init_q     <= 1'b1;
      step_q     <= '0;
      bin_occ_q  <= '0;
      bin_free_q <= '0;
      bcd_occ_q  <= '0;
      bcd_free_q <= '0;
      dig_occ_q  <= '0;
      dig_free_q <= '0;
    end else if (start) begin
      busy_q     <= 1'b1;
      pend_q     <= 1'b0;
      init_q     <= 1'b0;
      step_q     <= '0;
      bin_occ_q  <= occ_q;
      bin_free_q <= Cap14 - occ_q;
      bcd_occ_q  <= '0;
      bcd_free_q <= '0;
    end else if (busy_q) begin
      // A count change mid-conversion is remembered and converted once this run finishes.
      if (chg_q) pend_q <= 1'b1;
      bcd_occ_q  <= nxt_occ;
      bcd_free_q <= nxt_free;
      bin_occ_q  <= {bin_occ_q[12:0], 1'b0};
      bin_free_q <= {bin_free_q[12:0], 1'b0};
      step_q     <= step_q + 4'd1;
      if (step_q == 4'd13) begin
        busy_q     <= 1'b0;
        dig_occ_q  <= nxt_occ;
        dig_free_q <= nxt_free;
      end
    end
  end

  assign d0_o        = dig_free_q[3:0];
  assign d1_o        = dig_free_q[7:4];
  assign d2_o        = dig_free_q[11:8];
  assign d3_o        = dig_free_q[15:12];
  assign d4_o        = dig_occ_q[3:0];
  assign d5_o        = dig_occ_q[7:4];
  assign d6_o        = dig_occ_q[11:8];
  assign d7_o        = dig_occ_q[15:12];
  assign text_mode_o = show_text_i | err_q;
  assign slow_o      = slow_q;
  assign med_o       = med_q;
  assign fast_o      = fast_q;
  assign error_o     = err_q;
  assign occupied_o  = occ_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl with CAPACITY=99, DEB_CYCLES=4, ERR_HOLD=20.
module tb_parking_occupancy_ctrl;

  logic        clk, rst, car_in, car_out, show_text;
  logic [3:0]  d0, d1, d2, d3, d4, d5, d6, d7;
  logic        text_mode, slow, med, fast, error, full, empty;
  logic [13:0] occupied;
  int          n_pass = 0;
  int          n_total = 0;

  parking_occupancy_ctrl #(
    .CAPACITY  (99),
    .DEB_CYCLES(4),
    .ERR_HOLD  (20)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .car_in_i   (car_in),
    .car_out_i  (car_out),
    .show_text_i(show_text),
    .d0_o       (d0),
    .d1_o       (d1),
    .d2_o       (d2),
    .d3_o       (d3),
    .d4_o       (d4),
    .d5_o       (d5),
    .d6_o       (d6),
    .d7_o       (d7),
    .text_mode_o(text_mode),
    .slow_o     (slow),
    .med_o      (med),
    .fast_o     (fast),
    .error_o    (error),
    .occupied_o (occupied),
    .full_o     (full),
    .empty_o    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(17);
  endtask

  // Raw edge at cycle 0, count updates on edge 7, sensor is fully released by edge 14.
  task automatic enter_car();
    car_in = 1'b1;
    tick(6);
    car_in = 1'b0;
    tick(8);
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({occupied, empty, full, error} !== {14'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_count: got occ=%0d e=%b f=%b err=%b want 0 1 0 0",
               occupied, empty, full, error);
    else n_pass++;
    n_total++;
    if ({d7, d6, d5, d4, d3, d2, d1, d0} !== 32'h0)
      $display("FAIL reset_digits: got %h want 00000000", {d7, d6, d5, d4, d3, d2, d1, d0});
    else n_pass++;
    n_total++;
    if ({slow, med, fast, text_mode} !== 4'b1000)
      $display("FAIL reset_flags: got %b want 1000", {slow, med, fast, text_mode});
    else n_pass++;
    tick(2);
    rst = 1'b0;
    tick(17);
    n_total++;
    if ({d7, d6, d5, d4, d3, d2, d1, d0} !== 32'h0000_0099)
      $display("FAIL reset_conv: got %h want 00000099", {d7, d6, d5, d4, d3, d2, d1, d0});
    else n_pass++;
  endtask

  task automatic test_entry();
    car_in = 1'b1;
    tick(6);
    n_total++;
    if (occupied !== 14'd0) $display("FAIL entry_early: got %0d want 0", occupied);
    else n_pass++;
    tick(1);
    n_total++;
    if (occupied !== 14'd1) $display("FAIL entry_lat7: got %0d want 1", occupied);
    else n_pass++;
    tick(3);
    car_in = 1'b0;
    tick(20);
    n_total++;
    if ({d7, d6, d5, d4, d3, d2, d1, d0} !== 32'h0001_0098)
      $display("FAIL entry_digits: got %h want 00010098", {d7, d6, d5, d4, d3, d2, d1, d0});
    else n_pass++;
    car_in = 1'b1;
    tick(3);
    car_in = 1'b0;
    tick(15);
    n_total++;
    if (occupied !== 14'd1) $display("FAIL glitch: got %0d want 1", occupied);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int n = 2; n <= 99; n++) begin
      enter_car();
      n_total++;
      if (occupied !== 14'(n)) $display("FAIL fill_count: got %0d want %0d", occupied, n);
      else n_pass++;
      if (n == 24 || n == 25 || n == 74 || n == 75) begin
        n_total++;
        if ({slow, med, fast} !== ((n == 24) ? 3'b100 : (n == 75) ? 3'b001 : 3'b010))
          $display("FAIL fill_level_%0d: got %b", n, {slow, med, fast});
        else n_pass++;
      end
    end
    n_total++;
    if ({full, error, empty} !== 3'b100)
      $display("FAIL full_flag: got f/err/e=%b want 100", {full, error, empty});
    else n_pass++;
  endtask

  task automatic test_full_error();
    int n;
    car_in = 1'b1;
    tick(7);
    car_in = 1'b0;
    n_total++;
    if ({occupied, full, error, text_mode} !== {14'd99, 3'b111})
      $display("FAIL overfill: got occ=%0d f=%b err=%b tm=%b want 99 1 1 1",
               occupied, full, error, text_mode);
    else n_pass++;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!error) break;
      n++;
      tick(1);
    end
    n_total++;
    if (n !== 20) $display("FAIL err_hold: got %0d cycles want 20", n);
    else n_pass++;
    n_total++;
    if ({d7, d6, d5, d4, d3, d2, d1, d0} !== 32'h0099_0000)
      $display("FAIL full_digits: got %h want 00990000", {d7, d6, d5, d4, d3, d2, d1, d0});
    else n_pass++;
  endtask

  task automatic test_exit_empty();
    do_reset();
    car_out = 1'b1;
    tick(7);
    car_out = 1'b0;
    n_total++;
    if ({occupied, empty, error, text_mode} !== {14'd0, 3'b111})
      $display("FAIL underflow: got occ=%0d e=%b err=%b tm=%b want 0 1 1 1",
               occupied, empty, error, text_mode);
    else n_pass++;
    tick(8);
    car_out = 1'b1;
    tick(7);
    car_out = 1'b0;
    tick(12);
    n_total++;
    if (error !== 1'b1) $display("FAIL retrigger_held: got %b want 1", error);
    else n_pass++;
    tick(7);
    n_total++;
    if (error !== 1'b1) $display("FAIL retrigger_end: got %b want 1", error);
    else n_pass++;
    tick(2);
    n_total++;
    if ({error, text_mode} !== 2'b00) $display("FAIL err_clear: got %b want 00", {error, text_mode});
    else n_pass++;
    show_text = 1'b1;
    #1;
    n_total++;
    if (text_mode !== 1'b1) $display("FAIL show_text: got %b want 1", text_mode);
    else n_pass++;
    show_text = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (5) enter_car();
    car_in  = 1'b1;
    car_out = 1'b1;
    tick(7);
    car_in  = 1'b0;
    car_out = 1'b0;
    n_total++;
    if ({occupied, error} !== {14'd5, 1'b0})
      $display("FAIL simultaneous: got occ=%0d err=%b want 5 0", occupied, error);
    else n_pass++;
    tick(20);
    n_total++;
    if ({d7, d6, d5, d4, d3, d2, d1, d0} !== 32'h0005_0094)
      $display("FAIL simul_digits: got %h want 00050094", {d7, d6, d5, d4, d3, d2, d1, d0});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    car_in = 1'b1;
    tick(6);
    car_in  = 1'b0;
    car_out = 1'b1;
    tick(6);
    car_out = 1'b0;
    car_in  = 1'b1;
    tick(6);
    car_in = 1'b0;
    tick(50);
    n_total++;
    if (occupied !== 14'd6) $display("FAIL b2b_count: got %0d want 6", occupied);
    else n_pass++;
    n_total++;
    if ({d7, d6, d5, d4, d3, d2, d1, d0} !== 32'h0006_0093)
      $display("FAIL b2b_digits: got %h want 00060093", {d7, d6, d5, d4, d3, d2, d1, d0});
    else n_pass++;
    car_out = 1'b1;
    tick(10);
    car_out = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if ({occupied, empty, error, slow, med, fast} !== {14'd0, 5'b10100})
      $display("FAIL midconv_rst: got occ=%0d e=%b err=%b lvl=%b want 0 1 0 100",
               occupied, empty, error, {slow, med, fast});
    else n_pass++;
    n_total++;
    if ({d7, d6, d5, d4, d3, d2, d1, d0} !== 32'h0)
      $display("FAIL midconv_digits: got %h want 00000000", {d7, d6, d5, d4, d3, d2, d1, d0});
    else n_pass++;
    tick(2);
    rst = 1'b0;
    tick(17);
    n_total++;
    if ({d7, d6, d5, d4, d3, d2, d1, d0} !== 32'h0000_0099)
      $display("FAIL rerelease: got %h want 00000099", {d7, d6, d5, d4, d3, d2, d1, d0});
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    car_in    = 1'b0;
    car_out   = 1'b0;
    show_text = 1'b0;
    test_reset();
    test_entry();
    test_fill();
    test_full_error();
    test_exit_empty();
    test_simultaneous();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
